tff_updown_counter: RTL and testbench
=====================================

TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits; legal range 2..16.
REQ-002 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Rst  input  1  reset; synchronous, active-high.
REQ-004 Port: En  input  1  count enable; when low, no toggle is applied.
REQ-005 Port: Up  input  1  direction; 1 = count up, 0 = count down.
REQ-006 Port: Sat  input  1  mode; 1 = saturate at terminal value, 0 = wrap.
REQ-007 Port: Load  input  1  synchronous parallel load strobe.
REQ-008 Port: D  input  WIDTH  parallel load value.
REQ-009 Port: Q  output  WIDTH  registered count.
REQ-010 Port: Qbar  output  WIDTH  bitwise complement of Q at all times.
REQ-011 Port: T  output  WIDTH  per-bit toggle terms, combinational from current state and inputs.
REQ-012 Port: Tc  output  1  terminal count, combinational.
REQ-013 Port: Wrap  output  1  registered one-cycle pulse marking a wrap event.

Function
REQ-014 Each bit of Q SHALL be a T-type storage element: next Q[i] = Q[i] XOR T[i].
REQ-015 Up=1: T[0]=En; T[i]=En AND (Q[i-1:0] all ones), for i>=1.
REQ-016 Up=0: T[0]=En; T[i]=En AND (Q[i-1:0] all zeros), for i>=1.
REQ-017 Tc SHALL be 1 when En=1 and Q is at the terminal value for the current direction (all ones if Up=1, all zeros if Up=0); otherwise 0.
REQ-018 Sat=1 and Tc=1: T SHALL be forced to all zeros and Q holds.
REQ-019 Sat=0 and Tc=1: Q SHALL wrap (all ones -> 0 when up, 0 -> all ones when down), and Wrap SHALL be 1 in the following cycle only.
REQ-020 Wrap SHALL be 0 in every cycle not immediately following a wrap; consecutive wraps (WIDTH-bit counter at terminal each cycle) are not possible except via Load, and Wrap SHALL follow each qualifying edge.
REQ-021 Priority at each rising edge: Rst > Load > count (En) > hold.
REQ-022 Load=1: Q <= D regardless of En, Up and Sat; Wrap <= 0; T is ignored for that edge.
REQ-023 En=0 and Load=0: Q and Wrap SHALL hold/clear respectively (Q holds, Wrap <= 0).
REQ-024 Changing Up between cycles SHALL take effect on the next edge with no dead cycle; count latency is one clock from En sample to updated Q.
REQ-025 T and Tc SHALL reflect the Sat gating of REQ-018, so that T equals Q XOR next Q whenever Load=0 and Rst=0.
REQ-026 All arithmetic is modulo 2^WIDTH; no output is wider than WIDTH except as declared.

Reset
REQ-027 Rst=1 at a rising edge SHALL set Q=0, Qbar=all ones and Wrap=0, overriding Load and En.
REQ-028 Rst asserted mid-count SHALL take effect on that edge; counting resumes from 0 on the first edge with Rst=0.
REQ-029 No output SHALL be undefined after the first rising edge with Rst=1; before that edge, the state is unspecified.

Verification
REQ-030 Rst=1 for 2 cycles, then En=1, Up=1, Sat=0, WIDTH=4, 17 edges -> Q: 1,2,...,15,0,1; Tc=1 while Q=15; Wrap=1 exactly in the cycle where Q=0.
REQ-031 Load D=4'h3, then Up=0, En=1, Sat=1, 5 edges -> Q: 2,1,0,0,0; Tc=1 while Q=0; T=0 while Q=0; Wrap stays 0.
REQ-032 Q=4'h7, Up=1, En=1 -> T=4'b1111, next Q=4'h8; Qbar=4'h7 after the edge.
REQ-033 Load=1 with D=4'hA and En=1, Up=1 on the same edge -> Q=4'hA (load wins, no increment); Rst=1 with Load=1 on the same edge -> Q=0.
REQ-034 Counting at Q=4'h5, assert Rst for one edge -> Q=0 and Wrap=0 on that edge; next edge with En=1, Up=1 -> Q=1.
REQ-035 En=0 for 3 edges at Q=4'h9 -> Q stays 9, T=0, Tc=0, Wrap=0.

Source files
------------

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: WIDTH-bit up/down counter built from T-type state bits.
// Each bit toggles when all lower bits sit at the terminal value for the
// current direction. Supports saturate or wrap at terminal count, a parallel
// load, and a registered one-cycle pulse whenever the count wraps.
module tff_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Up,
    input  logic             Sat,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] T,
    output logic             Tc,
    output logic             Wrap
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] t_raw_s;
    logic [WIDTH-1:0] t_s;
    logic             tc_s;
    logic             run_s;

    // Ripple the toggle condition up the bits: bit i toggles when counting is
    // enabled and every lower bit is at the terminal level for the direction.
    // The final carry is En AND all bits terminal, which is the terminal count.
    always_comb begin
        t_raw_s = {WIDTH{1'b0}};
        run_s   = En;
        for (int i = 0; i < WIDTH; i++) begin
            t_raw_s[i] = run_s;
            if (Up) begin
                run_s = run_s & q_q[i];
            end else begin
                run_s = run_s & ~q_q[i];
            end
        end
        tc_s = run_s;
    end

    // In saturate mode a terminal count suppresses every toggle so Q holds.
    always_comb begin
        if (Sat && tc_s) begin
            t_s = {WIDTH{1'b0}};
        end else begin
            t_s = t_raw_s;
        end
    end

    // Next-state selection: load beats counting, counting beats hold. Wrap is
    // flagged only when a terminal count is passed through in wrap mode.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (Load) begin
            q_d    = D;
            wrap_d = 1'b0;
        end else if (En) begin
            q_d    = q_q ^ t_s;
            wrap_d = tc_s & ~Sat;
        end else begin
            q_d    = q_q;
            wrap_d = 1'b0;
        end
    end

    // State register with synchronous reset that overrides load and count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            q_q    <= {WIDTH{1'b0}};
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;
    assign T    = t_s;
    assign Tc   = tc_s;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed self-checking bench for tff_updown_counter at WIDTH = 4.
module tb_tff_updown_counter;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic       Up;
    logic       Sat;
    logic       Load;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] Qbar;
    logic [3:0] T;
    logic       Tc;
    logic       Wrap;

    int checks_cnt;
    int errors_cnt;

    tff_updown_counter #(.WIDTH(4)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .En   (En),
        .Up   (Up),
        .Sat  (Sat),
        .Load (Load),
        .D    (D),
        .Q    (Q),
        .Qbar (Qbar),
        .T    (T),
        .Tc   (Tc),
        .Wrap (Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_val(input logic [3:0] v);
        Load = 1'b1;
        D    = v;
        tick();
        Load = 1'b0;
        check_eq("load_q", {28'd0, Q}, {28'd0, v});
        check_eq("load_wrap", {31'd0, Wrap}, 32'd0);
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] nxt;
        logic [3:0] down_exp [5];

        checks_cnt = 0;
        errors_cnt = 0;
        Rst  = 1'b1;
        En   = 1'b0;
        Up   = 1'b1;
        Sat  = 1'b0;
        Load = 1'b0;
        D    = 4'h0;

        // Reset state
        tick();
        tick();
        check_eq("rst_q", {28'd0, Q}, 32'h0);
        check_eq("rst_qbar", {28'd0, Qbar}, 32'hF);
        check_eq("rst_wrap", {31'd0, Wrap}, 32'd0);

        // Up-count with wrap over 17 edges
        Rst = 1'b0;
        En  = 1'b1;
        Up  = 1'b1;
        Sat = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cur = 4'(k - 1);
            nxt = 4'(k);
            #1;
            check_eq("up_tc", {31'd0, Tc}, {31'd0, (cur == 4'hF)});
            check_eq("up_t", {28'd0, T}, {28'd0, cur ^ nxt});
            tick();
            check_eq("up_q", {28'd0, Q}, {28'd0, nxt});
            check_eq("up_wrap", {31'd0, Wrap}, {31'd0, (nxt == 4'h0)});
        end

        // Load 3 then count down saturating
        load_val(4'h3);
        Up  = 1'b0;
        En  = 1'b1;
        Sat = 1'b1;
        down_exp[0] = 4'h2;
        down_exp[1] = 4'h1;
        down_exp[2] = 4'h0;
        down_exp[3] = 4'h0;
        down_exp[4] = 4'h0;
        cur = 4'h3;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("dsat_tc", {31'd0, Tc}, {31'd0, (cur == 4'h0)});
            check_eq("dsat_t", {28'd0, T}, {28'd0, cur ^ down_exp[k]});
            tick();
            check_eq("dsat_q", {28'd0, Q}, {28'd0, down_exp[k]});
            check_eq("dsat_wrap", {31'd0, Wrap}, 32'd0);
            cur = down_exp[k];
        end

        // 7 -> 8 full carry
        load_val(4'h7);
        Up  = 1'b1;
        Sat = 1'b0;
        #1;
        check_eq("c7_t", {28'd0, T}, 32'hF);
        check_eq("c7_tc", {31'd0, Tc}, 32'd0);
        tick();
        check_eq("c7_q", {28'd0, Q}, 32'h8);
        check_eq("c7_qbar", {28'd0, Qbar}, 32'h7);

        // Direction change takes effect immediately
        Up = 1'b0;
        tick();
        check_eq("dir_q", {28'd0, Q}, 32'h7);
        Up = 1'b1;
        tick();
        check_eq("dir_q2", {28'd0, Q}, 32'h8);

        // Load beats count, reset beats load
        Load = 1'b1;
        D    = 4'hA;
        En   = 1'b1;
        Up   = 1'b1;
        tick();
        check_eq("ldwin_q", {28'd0, Q}, 32'hA);
        Rst = 1'b1;
        tick();
        check_eq("rstwin_q", {28'd0, Q}, 32'h0);
        check_eq("rstwin_wrap", {31'd0, Wrap}, 32'd0);
        Rst  = 1'b0;
        Load = 1'b0;

        // Load at terminal, wrap, then load clears wrap
        load_val(4'hF);
        Sat = 1'b0;
        tick();
        check_eq("lw_q", {28'd0, Q}, 32'h0);
        check_eq("lw_wrap", {31'd0, Wrap}, 32'd1);
        load_val(4'hF);
        tick();
        check_eq("lw2_wrap", {31'd0, Wrap}, 32'd1);
        tick();
        check_eq("lw3_q", {28'd0, Q}, 32'h1);
        check_eq("lw3_wrap", {31'd0, Wrap}, 32'd0);

        // Down wrap 0 -> F
        load_val(4'h0);
        Up = 1'b0;
        #1;
        check_eq("dw_tc", {31'd0, Tc}, 32'd1);
        check_eq("dw_t", {28'd0, T}, 32'hF);
        tick();
        check_eq("dw_q", {28'd0, Q}, 32'hF);
        check_eq("dw_wrap", {31'd0, Wrap}, 32'd1);
        tick();
        check_eq("dw2_q", {28'd0, Q}, 32'hE);
        check_eq("dw2_wrap", {31'd0, Wrap}, 32'd0);

        // Up saturate at F
        load_val(4'hF);
        Up  = 1'b1;
        Sat = 1'b1;
        #1;
        check_eq("usat_tc", {31'd0, Tc}, 32'd1);
        check_eq("usat_t", {28'd0, T}, 32'h0);
        tick();
        check_eq("usat_q", {28'd0, Q}, 32'hF);
        check_eq("usat_wrap", {31'd0, Wrap}, 32'd0);
        Sat = 1'b0;

        // Reset mid-count, then resume from 0
        load_val(4'h4);
        tick();
        check_eq("mid_q", {28'd0, Q}, 32'h5);
        Rst = 1'b1;
        tick();
        check_eq("mid_rst_q", {28'd0, Q}, 32'h0);
        check_eq("mid_rst_wrap", {31'd0, Wrap}, 32'd0);
        Rst = 1'b0;
        tick();
        check_eq("mid_resume_q", {28'd0, Q}, 32'h1);

        // Hold with En low
        load_val(4'h9);
        En = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("hold_t", {28'd0, T}, 32'h0);
            check_eq("hold_tc", {31'd0, Tc}, 32'd0);
            tick();
            check_eq("hold_q", {28'd0, Q}, 32'h9);
            check_eq("hold_wrap", {31'd0, Wrap}, 32'd0);
        end

        // Wrap pulse cleared by En low
        load_val(4'hF);
        En = 1'b1;
        tick();
        check_eq("wen_wrap", {31'd0, Wrap}, 32'd1);
        En = 1'b0;
        tick();
        check_eq("wen_wrap2", {31'd0, Wrap}, 32'd0);
        check_eq("wen_q", {28'd0, Q}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
